reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid / a_addr / a_data  in  1/4/16  requester A (ALU writeback) write request
- a_ready  out  1  A request accepted this cycle
- b_valid / b_addr / b_data  in  1/4/16  requester B (memory writeback) write request
- b_ready  out  1  B request accepted this cycle
- r15_valid / r15_data  in  1/16  dedicated R15 write request, no handshake
- W_addr / W_data / reg_WE  out  4/16/1  register-file general write port
- W_R15 / R15_WE  out  16/1  register-file R15 write port
- pend_mask  out  16  one bit per register with a write in flight
REQ-002 Parameters: none.

Function
REQ-003 Transfer SHALL occur when valid&ready, with ready combinational and requesters holding valid/addr/data stable until accepted.
REQ-004 At most one of a_ready, b_ready SHALL be high per cycle for an addr≠0 request.
REQ-005 The block SHALL register the granted request and drive W_addr/W_data with reg_WE=1 for exactly one cycle, on the edge after acceptance (latency 1).
REQ-006 With no grant, reg_WE SHALL be 0 and W_addr/W_data SHALL hold their last values.
REQ-007 The arbiter SHALL have two states: PRI_A (A wins conflicts) and PRI_B (B wins conflicts).
REQ-008 A 2-bit starvation counter SHALL increment each cycle B is valid, eligible and not granted.
REQ-009 The counter SHALL clear when B is granted or b_valid=0.
REQ-010 PRI_A SHALL move to PRI_B when the counter is 3 at a clock edge.
REQ-011 PRI_B SHALL return to PRI_A on the edge after B is granted or when b_valid=0.
REQ-012 When only one requester is valid and eligible, it SHALL be granted regardless of state.
REQ-013 A request with addr=0 SHALL be accepted immediately (ready=1), consume no grant, not affect the counter, and not produce reg_WE; A and B may both be accepted this way in one cycle.
REQ-014 r15_valid SHALL be registered to W_R15 with R15_WE=1 for one cycle on the next edge, unconditionally.
REQ-015 A general request with addr=15 SHALL be ineligible in any cycle r15_valid=1; it is stalled (ready=0) and the other requester may be granted.
REQ-016 Consequently reg_WE and R15_WE SHALL never both be 1 with W_addr=15.
REQ-017 pend_mask SHALL be combinational: bit[a_addr] when a_valid, bit[b_addr] when b_valid, bit[W_addr] when reg_WE, bit[15] when r15_valid or R15_WE.
REQ-018 pend_mask[0] SHALL always be 0.
REQ-019 Both requesters targeting the same address SHALL be arbitrated normally; the write order on the port SHALL equal the grant order.

Reset
REQ-020 While rst=0 the block SHALL drive a_ready=0, b_ready=0, reg_WE=0, R15_WE=0, W_addr=0, W_data=0, W_R15=0, state=PRI_A and counter=0.
REQ-021 Reset asserted mid-transfer SHALL drop any registered but unissued write; no reg_WE or R15_WE SHALL follow reset release until a new acceptance.
REQ-022 pend_mask SHALL still reflect the valid inputs during reset.

Verification
REQ-023 Single requester: a_valid=1, a_addr=3, a_data=16'h1b18 for 1 cycle -> a_ready=1 that cycle; next cycle reg_WE=1, W_addr=3, W_data=16'h1b18.
REQ-024 Starvation: a_valid and b_valid held high, distinct addrs≠0,15 -> A granted cycles 0-2, counter reaches 3, B granted cycle 4 (PRI_B), A granted cycle 5.
REQ-025 R15 conflict: a_valid=1, a_addr=15, data=16'h0002, with r15_valid=1, r15_data=16'h0011 -> cycle 1: a_ready=0, R15_WE=1, W_R15=16'h0011; r15_valid=0 then -> A accepted, reg_WE=1, W_addr=15, W_data=16'h0002 one cycle later.
REQ-026 Addr 0: a_addr=0 and b_addr=0 both valid -> a_ready=b_ready=1 same cycle, reg_WE stays 0, pend_mask[0]=0.
REQ-027 Reset mid-operation: b accepted, rst=0 before the next edge -> reg_WE=0 and all outputs 0; after release, no write issues until a new request.
REQ-028 pend_mask: a_valid, a_addr=5 and b_valid, b_addr=9, with both stalled -> pend_mask=16'h0220.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
// Arbitrates two register-file writeback requesters (A = ALU, B = memory)
// onto a single general write port. A separate R15 write port is fed
// unconditionally from r15_valid/r15_data. Priority toggles between A and B
// through a starvation counter. Addr-0 requests are accepted and discarded.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous reset, active low
//   a_valid/a_addr/a_data     requester A write request
//   a_ready                   A request accepted this cycle (combinational)
//   b_valid/b_addr/b_data     requester B write request
//   b_ready                   B request accepted this cycle (combinational)
//   r15_valid/r15_data        dedicated R15 write, no handshake
//   W_addr/W_data/reg_WE      general register-file write port (latency 1)
//   W_R15/R15_WE              R15 register-file write port (latency 1)
//   pend_mask                 one bit per register with a write in flight
// ---------------------------------------------------------------------------
module reg_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [3:0]  a_addr,
   input  logic [15:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [3:0]  b_addr,
   input  logic [15:0] b_data,
   output logic        b_ready,
   input  logic        r15_valid,
   input  logic [15:0] r15_data,
   output logic [3:0]  W_addr,
   output logic [15:0] W_data,
   output logic        reg_WE,
   output logic [15:0] W_R15,
   output logic        R15_WE,
   output logic [15:0] pend_mask
);

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;

   logic [3:0]  w_addr_q, w_addr_d;
   logic [15:0] w_data_q, w_data_d;
   logic        reg_we_q, reg_we_d;
   logic [15:0] w_r15_q, w_r15_d;
   logic        r15_we_q, r15_we_d;

   logic a_zero, b_zero;
   logic a_elig, b_elig;
   logic grant_a, grant_b;

   // Eligibility: addr 0 is a sink, and addr 15 must yield to the dedicated
   // R15 port in the same cycle so the two ports never write R15 together.
   always_comb begin
      a_zero  = a_valid & (a_addr == 4'd0);
      b_zero  = b_valid & (b_addr == 4'd0);
      a_elig  = a_valid & (a_addr != 4'd0) & ~((a_addr == 4'hF) & r15_valid);
      b_elig  = b_valid & (b_addr != 4'd0) & ~((b_addr == 4'hF) & r15_valid);
      grant_a = a_elig & (~b_elig | (state_q == PRI_A));
      grant_b = b_elig & (~a_elig | (state_q == PRI_B));
      a_ready = rst & (a_zero | grant_a);
      b_ready = rst & (b_zero | grant_b);
   end

   // Priority FSM and starvation counter. The counter saturates at 3 so a
   // conflict lost while the state is still switching cannot wrap it to 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!b_valid || grant_b) begin
         cnt_d = 2'd0;
      end else if (b_elig && (cnt_q != 2'd3)) begin
         cnt_d = cnt_q + 2'd1;
      end
      case (state_q)
         PRI_A: if (cnt_q == 2'd3) state_d = PRI_B;
         PRI_B: if (grant_b || !b_valid) state_d = PRI_A;
         default: state_d = PRI_A;
      endcase
   end

   // Write-port next state: hold address/data when idle, strobe for one cycle.
   always_comb begin
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      reg_we_d = 1'b0;
      w_r15_d  = w_r15_q;
      r15_we_d = 1'b0;
      if (grant_a) begin
         w_addr_d = a_addr;
         w_data_d = a_data;
         reg_we_d = 1'b1;
      end else if (grant_b) begin
         w_addr_d = b_addr;
         w_data_d = b_data;
         reg_we_d = 1'b1;
      end
      if (r15_valid) begin
         w_r15_d  = r15_data;
         r15_we_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= PRI_A;
         cnt_q    <= 2'd0;
         w_addr_q <= 4'd0;
         w_data_q <= 16'd0;
         reg_we_q <= 1'b0;
         w_r15_q  <= 16'd0;
         r15_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         reg_we_q <= reg_we_d;
         w_r15_q  <= w_r15_d;
         r15_we_q <= r15_we_d;
      end
   end

   assign W_addr = w_addr_q;
   assign W_data = w_data_q;
   assign reg_WE = reg_we_q;
   assign W_R15  = w_r15_q;
   assign R15_WE = r15_we_q;

   // In-flight mask stays live during reset since it only reflects inputs
   // and the (already cleared) write strobes.
   always_comb begin
      pend_mask = 16'd0;
      if (a_valid)               pend_mask[a_addr] = 1'b1;
      if (b_valid)               pend_mask[b_addr] = 1'b1;
      if (reg_we_q)              pend_mask[w_addr_q] = 1'b1;
      if (r15_valid || r15_we_q) pend_mask[15] = 1'b1;
      pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid, r15_valid;
   logic [3:0]  a_addr, b_addr;
   logic [15:0] a_data, b_data, r15_data;
   logic        a_ready, b_ready;
   logic [3:0]  W_addr;
   logic [15:0] W_data, W_R15, pend_mask;
   logic        reg_WE, R15_WE;

   reg_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .r15_valid(r15_valid), .r15_data(r15_data),
      .W_addr(W_addr), .W_data(W_data), .reg_WE(reg_WE),
      .W_R15(W_R15), .R15_WE(R15_WE), .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [3:0] addr; logic [15:0] data; int cyc;} wr_t;
   typedef struct {logic [15:0] data; int cyc;} r15_t;
   wr_t  wr_q[$];
   r15_t r15_q[$];

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      wr_q.push_back(e);
   endtask

   task automatic push_r15(input logic [15:0] d);
      r15_t e;
      e.data = d; e.cyc = cyc + 1;
      r15_q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge; combinational checks follow at +1.
   task automatic step(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                       input logic rv, input logic [15:0] rd);
      @(negedge clk);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      r15_valid = rv; r15_data = rd;
      #1;
   endtask

   task automatic idle();
      step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0, 0, 16'd0);
   endtask

   // Monitor: pops expected writes whenever the DUT strobes a write port.
   always @(negedge clk) begin
      if (reg_WE) begin
         if (wr_q.size() == 0) chk("unexpected_reg_WE", {28'd0, W_addr}, 32'hFFFF_FFFF);
         else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("W_addr", {28'd0, W_addr}, {28'd0, e.addr});
            chk("W_data", {16'd0, W_data}, {16'd0, e.data});
            chk("W_cycle", cyc, e.cyc);
         end
      end
      if (R15_WE) begin
         if (r15_q.size() == 0) chk("unexpected_R15_WE", {16'd0, W_R15}, 32'hFFFF_FFFF);
         else begin
            r15_t e;
            e = r15_q.pop_front();
            chk("W_R15", {16'd0, W_R15}, {16'd0, e.data});
            chk("R15_cycle", cyc, e.cyc);
         end
      end
      if (reg_WE && R15_WE) chk("r15_port_collision", {31'd0, W_addr == 4'hF}, 32'd0);
   end

   initial begin
      logic [1:0] exp_rdy [6];
      exp_rdy = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

      // Reset state; pend_mask stays live with both requesters held off.
      rst = 1'b0;
      a_valid = 1; a_addr = 4'd5; a_data = 16'h1111;
      b_valid = 1; b_addr = 4'd9; b_data = 16'h2222;
      r15_valid = 0; r15_data = 16'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
      chk("rst_reg_WE",  {31'd0, reg_WE}, 32'd0);
      chk("rst_R15_WE",  {31'd0, R15_WE}, 32'd0);
      chk("rst_W_addr",  {28'd0, W_addr}, 32'd0);
      chk("rst_W_data",  {16'd0, W_data}, 32'd0);
      chk("rst_W_R15",   {16'd0, W_R15}, 32'd0);
      chk("rst_pend_mask", {16'd0, pend_mask}, 32'h0220);
      @(negedge clk);
      a_valid = 0; b_valid = 0;
      rst = 1'b1;
      idle(); idle();

      // Single requester A, latency 1.
      step(1, 4'd3, 16'h1b18, 0, 4'd0, 16'd0, 0, 16'd0);
      chk("single_rdy", {30'd0, a_ready, b_ready}, 32'b10);
      push_wr(4'd3, 16'h1b18);
      idle();
      chk("pend_inflight_w3", {16'd0, pend_mask}, 32'h0008);
      idle();

      // Starvation: A wins until counter saturates, then B once, then A.
      for (int i = 0; i < 6; i++) begin
         step(1, 4'd2, 16'hA000 + 16'(i), 1, 4'd7, (i < 5) ? 16'hB000 : 16'hB001, 0, 16'd0);
         chk($sformatf("starve_rdy_%0d", i), {30'd0, a_ready, b_ready}, {30'd0, exp_rdy[i]});
         if (exp_rdy[i] == 2'b10) push_wr(4'd2, 16'hA000 + 16'(i));
         else                     push_wr(4'd7, 16'hB000);
      end
      idle(); idle();

      // R15 conflict: A (addr 15) stalls, B takes the port instead.
      step(1, 4'hF, 16'h0002, 1, 4'd4, 16'h0B04, 1, 16'h0011);
      chk("r15_conf_rdy", {30'd0, a_ready, b_ready}, 32'b01);
      chk("r15_conf_pend", {16'd0, pend_mask}, 32'h8010);
      push_wr(4'd4, 16'h0B04);
      push_r15(16'h0011);
      step(1, 4'hF, 16'h0002, 0, 4'd0, 16'd0, 0, 16'd0);
      chk("r15_free_rdy", {30'd0, a_ready, b_ready}, 32'b10);
      chk("r15_free_pend", {16'd0, pend_mask}, 32'h8010);
      push_wr(4'hF, 16'h0002);
      idle();
      chk("pend_inflight_w15", {16'd0, pend_mask}, 32'h8000);
      idle();

      // Addr 0: both accepted, no write, no pend bit.
      step(1, 4'd0, 16'hDEAD, 1, 4'd0, 16'hBEEF, 0, 16'd0);
      chk("zero_rdy", {30'd0, a_ready, b_ready}, 32'b11);
      chk("zero_pend", {16'd0, pend_mask}, 32'h0000);
      // Addr 0 on A does not block a real B request.
      step(1, 4'd0, 16'hDEAD, 1, 4'd4, 16'h0044, 0, 16'd0);
      chk("zero_mix_rdy", {30'd0, a_ready, b_ready}, 32'b11);
      push_wr(4'd4, 16'h0044);
      idle(); idle();

      // Same address from both: write order follows grant order.
      step(1, 4'd8, 16'h0A08, 1, 4'd8, 16'h0B08, 0, 16'd0);
      chk("same_addr_rdy0", {30'd0, a_ready, b_ready}, 32'b10);
      push_wr(4'd8, 16'h0A08);
      step(0, 4'd0, 16'd0, 1, 4'd8, 16'h0B08, 0, 16'd0);
      chk("same_addr_rdy1", {30'd0, a_ready, b_ready}, 32'b01);
      push_wr(4'd8, 16'h0B08);
      idle(); idle();

      // Reset right after acceptance: registered writes are dropped.
      step(0, 4'd0, 16'd0, 1, 4'd6, 16'h6666, 1, 16'h7777);
      chk("rst_mid_b_rdy", {31'd0, b_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_valid = 1; a_addr = 4'd3; a_data = 16'h3333;
      b_valid = 0; r15_valid = 0;
      #1;
      chk("rst_mid_reg_WE", {31'd0, reg_WE}, 32'd0);
      chk("rst_mid_R15_WE", {31'd0, R15_WE}, 32'd0);
      chk("rst_mid_W_addr", {28'd0, W_addr}, 32'd0);
      chk("rst_mid_W_data", {16'd0, W_data}, 32'd0);
      chk("rst_mid_W_R15",  {16'd0, W_R15}, 32'd0);
      chk("rst_mid_a_ready", {31'd0, a_ready}, 32'd0);
      @(negedge clk);
      a_valid = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) idle();

      chk("wr_queue_drained",  wr_q.size(), 32'd0);
      chk("r15_queue_drained", r15_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
